// File: rtl/uart_reg_sched_if.sv
// Register-port bundle: two requesting masters on one side, the UART16650
// register block on the other. The scheduler uses the slave modport.
interface uart_reg_sched_if #(
    parameter int ADDR_W = 3
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [7:0]        m0_wdat;
    logic              m0_ack;
    logic [7:0]        m0_rdat;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [7:0]        m1_wdat;
    logic              m1_ack;
    logic [7:0]        m1_rdat;

    logic [ADDR_W-1:0] u_addr;
    logic [7:0]        u_dat_o;
    logic              u_we;
    logic              u_re;
    logic [7:0]        u_dat_i;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdat,
        output m0_ack, m0_rdat,
        input  m1_req, m1_we, m1_addr, m1_wdat,
        output m1_ack, m1_rdat,
        output u_addr, u_dat_o, u_we, u_re,
        input  u_dat_i
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdat,
        input  m0_ack, m0_rdat,
        output m1_req, m1_we, m1_addr, m1_wdat,
        input  m1_ack, m1_rdat,
        input  u_addr, u_dat_o, u_we, u_re,
        output u_dat_i
    );
endinterface

// File: rtl/uart_reg_sched.sv
// UART register-port scheduler: runs the configuration write sequence, then
// shares the register port between two masters with round-robin arbitration.
module uart_reg_sched #(
    parameter int         ADDR_W      = 3,
    parameter logic [7:0] LCR_DEFAULT = 8'h03,
    parameter logic [7:0] FCR_DEFAULT = 8'hC0,
    parameter logic [7:0] IER_DEFAULT = 8'h00,
    parameter logic [7:0] MCR_DEFAULT = 8'h03
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              cfg_start,
    input  logic [15:0]       cfg_div,
    output logic              cfg_busy,
    output logic              cfg_done,
    uart_reg_sched_if.slave   bus
);
    localparam logic [ADDR_W-1:0] A_TR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_IE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_FC = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_LC = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_MC = ADDR_W'(4);
    localparam logic [2:0]        LAST_STEP = 3'd6;

    typedef enum logic [2:0] {INIT_W, INIT_G, IDLE, ISSUE, CAPT, GAP} state_t;

    state_t            state;
    logic [2:0]        step;
    logic [15:0]       div_q;
    logic              start_pend;
    logic              rr_ptr;
    logic              gnt;
    logic              g_we;
    logic [1:0]        ack;
    logic [7:0]        rdat0, rdat1;
    logic [ADDR_W-1:0] u_addr;
    logic [7:0]        u_dat_o;
    logic              u_we, u_re;

    logic              any_req, pick;
    logic [ADDR_W-1:0] init_addr;
    logic [7:0]        init_dat;

    assign bus.m0_ack  = ack[0];
    assign bus.m1_ack  = ack[1];
    assign bus.m0_rdat = rdat0;
    assign bus.m1_rdat = rdat1;
    assign bus.u_addr  = u_addr;
    assign bus.u_dat_o = u_dat_o;
    assign bus.u_we    = u_we;
    assign bus.u_re    = u_re;

    // Round-robin pick: the pointer names the master that wins a tie.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        if (rr_ptr) pick = bus.m1_req ? 1'b1 : 1'b0;
        else        pick = bus.m0_req ? 1'b0 : 1'b1;
    end

    // NOTE: every output of an always_comb gets a default first, otherwise an unlisted case infers a latch.
    always_comb begin
        init_addr = A_LC;
        init_dat  = 8'h83;
        case (step)
            3'd1:    begin init_addr = A_TR; init_dat = div_q[7:0];  end
            3'd2:    begin init_addr = A_IE; init_dat = div_q[15:8]; end
            3'd3:    begin init_addr = A_LC; init_dat = LCR_DEFAULT; end
            3'd4:    begin init_addr = A_FC; init_dat = FCR_DEFAULT; end
            3'd5:    begin init_addr = A_IE; init_dat = IER_DEFAULT; end
            3'd6:    begin init_addr = A_MC; init_dat = MCR_DEFAULT; end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= INIT_W;
            step       <= '0;
            div_q      <= cfg_div;
            start_pend <= 1'b0;
            cfg_busy   <= 1'b1;
            cfg_done   <= 1'b0;
            rr_ptr     <= 1'b0;
            gnt        <= 1'b0;
            g_we       <= 1'b0;
            ack        <= '0;
            rdat0      <= '0;
            rdat1      <= '0;
            u_addr     <= '0;
            u_dat_o    <= '0;
            u_we       <= 1'b0;
            u_re       <= 1'b0;
        end else begin
            ack  <= '0;
            u_we <= 1'b0;
            u_re <= 1'b0;
            if (cfg_start) start_pend <= 1'b1;
            case (state)
                INIT_W: begin
                    u_addr  <= init_addr;
                    u_dat_o <= init_dat;
                    u_we    <= 1'b1;
                    state   <= INIT_G;
                end
                INIT_G: begin
                    if (step == LAST_STEP) begin
                        cfg_busy <= 1'b0;
                        cfg_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        step  <= step + 3'd1;
                        state <= INIT_W;
                    end
                end
                IDLE: begin
                    // A start seen mid-transaction is remembered and served here.
                    if (cfg_start || start_pend) begin
                        div_q      <= cfg_div;
                        step       <= '0;
                        start_pend <= 1'b0;
                        cfg_done   <= 1'b0;
                        cfg_busy   <= 1'b1;
                        state      <= INIT_W;
                    end else if (any_req) begin
                        gnt    <= pick;
                        rr_ptr <= ~pick;
                        if (pick) begin
                            u_addr  <= bus.m1_addr;
                            u_dat_o <= bus.m1_wdat;
                            u_we    <= bus.m1_we;
                            u_re    <= ~bus.m1_we;
                            g_we    <= bus.m1_we;
                        end else begin
                            u_addr  <= bus.m0_addr;
                            u_dat_o <= bus.m0_wdat;
                            u_we    <= bus.m0_we;
                            u_re    <= ~bus.m0_we;
                            g_we    <= bus.m0_we;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= CAPT;
                CAPT: begin
                    ack[gnt] <= 1'b1;
                    if (!g_we) begin
                        if (gnt) rdat1 <= bus.u_dat_i;
                        else     rdat0 <= bus.u_dat_i;
                    end
                    state <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_reg_sched.sv
// Self-checking bench for uart_reg_sched: bus-strobe and ack scoreboards fed
// by a vector table and hand-written multi-cycle sequences.
module tb_uart_reg_sched;
    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        cfg_start;
    logic [15:0] cfg_div;
    logic        cfg_busy, cfg_done;

    always #5 clk = ~clk;

    uart_reg_sched_if #(.ADDR_W(3)) bus ();

    uart_reg_sched #(.ADDR_W(3)) dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .cfg_start(cfg_start),
        .cfg_div  (cfg_div),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .bus      (bus)
    );

    typedef struct { bit we; logic [2:0] addr; logic [7:0] dat; } bus_t;
    typedef struct { bit m; bit we; logic [2:0] addr; logic [7:0] wdat; logic [7:0] rsp; } vec_t;

    int   checks = 0, failures = 0;
    int   nstrobe = 0, nack0 = 0, nack1 = 0, issued0 = 0, issued1 = 0;
    int   both_hi = 0, consec = 0, mgap = 100;
    bit   prev_strobe = 1'b0;
    logic [7:0] rsp [8];
    logic [7:0] last_rd [2];
    bus_t       exp_bus [$];
    logic [7:0] exp_rd0 [$];
    logic [7:0] exp_rd1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus/ack monitor plus the register-block read model.
    always @(negedge clk) begin
        bus_t e;
        logic [7:0] r;
        bit strobe;
        strobe = bus.u_we | bus.u_re;
        if (bus.u_we && bus.u_re) both_hi++;
        if (strobe && prev_strobe) consec++;
        prev_strobe = strobe;
        if (strobe) begin
            nstrobe++;
            if (!cfg_busy) begin
                check("master_strobe_gap", mgap >= 3, 1);
                mgap = 0;
            end else mgap++;
            check("bus_expected", exp_bus.size() > 0, 1);
            if (exp_bus.size() > 0) begin
                e = exp_bus.pop_front();
                check("bus_we", bus.u_we, e.we);
                check("bus_addr", bus.u_addr, e.addr);
                if (e.we) check("bus_wdat", bus.u_dat_o, e.dat);
            end
            if (bus.u_re) bus.u_dat_i = rsp[bus.u_addr];
        end else mgap++;
        if (bus.m0_ack) begin
            nack0++;
            check("m0_ack_outside_init", cfg_busy, 0);
            check("m0_ack_expected", exp_rd0.size() > 0, 1);
            if (exp_rd0.size() > 0) begin
                r = exp_rd0.pop_front();
                check("m0_rdat", bus.m0_rdat, r);
            end
        end
        if (bus.m1_ack) begin
            nack1++;
            check("m1_ack_outside_init", cfg_busy, 0);
            check("m1_ack_expected", exp_rd1.size() > 0, 1);
            if (exp_rd1.size() > 0) begin
                r = exp_rd1.pop_front();
                check("m1_rdat", bus.m1_rdat, r);
            end
        end
    end

    task automatic push_init(input logic [15:0] div);
        exp_bus.push_back('{1'b1, 3'd3, 8'h83});
        exp_bus.push_back('{1'b1, 3'd0, div[7:0]});
        exp_bus.push_back('{1'b1, 3'd1, div[15:8]});
        exp_bus.push_back('{1'b1, 3'd3, 8'h03});
        exp_bus.push_back('{1'b1, 3'd2, 8'hC0});
        exp_bus.push_back('{1'b1, 3'd1, 8'h00});
        exp_bus.push_back('{1'b1, 3'd4, 8'h03});
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #1;
            got = cfg_done;
        end
        check(name, got, 1);
    endtask

    // One master access: raise req, wait (bounded) for its ack, drop req.
    task automatic do_access(input bit m, input bit we, input logic [2:0] addr,
                             input logic [7:0] wdat, input logic [7:0] rsp_v, input bit push_bus);
        int base;
        bit got = 1'b0;
        if (!we) rsp[addr] = rsp_v;
        if (push_bus) exp_bus.push_back('{we, addr, we ? wdat : 8'h00});
        if (!m) begin
            exp_rd0.push_back(we ? last_rd[0] : rsp_v);
            if (!we) last_rd[0] = rsp_v;
            issued0++;
            base = nack0;
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdat = wdat; bus.m0_req = 1'b1;
        end else begin
            exp_rd1.push_back(we ? last_rd[1] : rsp_v);
            if (!we) last_rd[1] = rsp_v;
            issued1++;
            base = nack1;
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdat = wdat; bus.m1_req = 1'b1;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            got = (m ? nack1 : nack0) != base;
        end
        check(m ? "m1_ack_seen" : "m0_ack_seen", got, 1);
        if (m) bus.m1_req = 1'b0;
        else   bus.m0_req = 1'b0;
    endtask

    vec_t vecs [7];
    int   busy_cnt, done_in_busy, base_strobe;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 3'd5, 8'h00, 8'h60};
        vecs[1] = '{1'b1, 1'b1, 3'd4, 8'h10, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 3'd6, 8'h00, 8'hB5};
        vecs[3] = '{1'b0, 1'b1, 3'd3, 8'h83, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h41};
        vecs[5] = '{1'b0, 1'b0, 3'd2, 8'h00, 8'hC1};
        vecs[6] = '{1'b1, 1'b1, 3'd0, 8'h5A, 8'h00};
        foreach (rsp[i]) rsp[i] = 8'h00;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        wb_rst_i = 1'b1; cfg_start = 1'b0; cfg_div = 16'h001B;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdat = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdat = '0;
        bus.u_dat_i = 8'h00;

        // Reset state, then the power-up configuration sequence.
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", cfg_busy, 1);
        check("rst_done", cfg_done, 0);
        check("rst_u_we", bus.u_we, 0);
        check("rst_u_re", bus.u_re, 0);
        check("rst_u_addr", bus.u_addr, 0);
        check("rst_m0_ack", bus.m0_ack, 0);
        check("rst_m0_rdat", bus.m0_rdat, 0);
        push_init(16'h001B);
        wb_rst_i = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (i == 13) begin
                check("init_done_cycle13", cfg_done, 0);
                check("init_busy_cycle13", cfg_busy, 1);
            end
        end
        check("init_done_cycle14", cfg_done, 1);
        check("init_busy_cycle14", cfg_busy, 0);
        check("init_bus_drained", exp_bus.size(), 0);

        // Single-master accesses from the vector table.
        @(negedge clk); #1;
        foreach (vecs[i])
            do_access(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdat, vecs[i].rsp, 1'b1);

        // Both masters hold req: grants must alternate m0, m1, m0, m1.
        exp_bus.push_back('{1'b0, 3'd1, 8'h00});
        exp_bus.push_back('{1'b0, 3'd2, 8'h00});
        exp_bus.push_back('{1'b0, 3'd3, 8'h00});
        exp_bus.push_back('{1'b0, 3'd6, 8'h00});
        fork
            begin do_access(1'b0, 1'b0, 3'd1, 8'h00, 8'h11, 1'b0); do_access(1'b0, 1'b0, 3'd3, 8'h00, 8'h33, 1'b0); end
            begin do_access(1'b1, 1'b0, 3'd2, 8'h00, 8'h22, 1'b0); do_access(1'b1, 1'b0, 3'd6, 8'h00, 8'h66, 1'b0); end
        join
        check("rr_bus_drained", exp_bus.size(), 0);

        // cfg_start pulsed during an m1 write; m0 then requests during init.
        cfg_div = 16'h0208;
        @(negedge clk); #1;
        fork
            do_access(1'b1, 1'b1, 3'd4, 8'h10, 8'h00, 1'b1);
            begin
                @(negedge clk); #1; cfg_start = 1'b1;
                @(negedge clk); #1; cfg_start = 1'b0;
            end
        join
        push_init(16'h0208);
        exp_bus.push_back('{1'b0, 3'd5, 8'h00});
        busy_cnt = 0; done_in_busy = 0;
        fork
            do_access(1'b0, 1'b0, 3'd5, 8'h00, 8'h77, 1'b0);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk); #1;
                    if (cfg_busy) begin
                        busy_cnt++;
                        if (cfg_done) done_in_busy++;
                    end
                    if (busy_cnt > 0 && cfg_done) break;
                end
            end
        join
        check("restart_busy_cycles", busy_cnt, 14);
        check("restart_done_cleared", done_in_busy, 0);
        check("restart_done_end", cfg_done, 1);
        check("restart_bus_drained", exp_bus.size(), 0);

        // Reset asserted while the third init write is on the bus.
        cfg_div = 16'h001B;
        push_init(16'h001B);
        base_strobe = nstrobe;
        cfg_start = 1'b1;
        @(negedge clk); #1; cfg_start = 1'b0;
        for (int i = 0; i < 20 && nstrobe < base_strobe + 3; i++) begin
            @(negedge clk); #1;
        end
        check("third_write_seen", nstrobe, base_strobe + 3);
        check("third_write_we", bus.u_we, 1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("async_rst_u_we", bus.u_we, 0);
        check("async_rst_busy", cfg_busy, 1);
        check("async_rst_done", cfg_done, 0);
        check("async_rst_u_addr", bus.u_addr, 0);
        check("async_rst_m0_rdat", bus.m0_rdat, 0);
        check("async_rst_m1_rdat", bus.m1_rdat, 0);
        exp_bus.delete();
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        push_init(16'h001B);
        repeat (2) @(negedge clk);
        #1 wb_rst_i = 1'b0;
        wait_done("reinit_done", 40);
        check("reinit_bus_drained", exp_bus.size(), 0);

        // Back-to-back m0 reads of RB.
        @(negedge clk); #1;
        do_access(1'b0, 1'b0, 3'd0, 8'h00, 8'hA1, 1'b1);
        do_access(1'b0, 1'b0, 3'd0, 8'h00, 8'hA2, 1'b1);
        do_access(1'b0, 1'b0, 3'd0, 8'h00, 8'hA3, 1'b1);

        repeat (4) @(negedge clk);
        #1;
        check("final_bus_drained", exp_bus.size(), 0);
        check("final_m0_acks", nack0, issued0);
        check("final_m1_acks", nack1, issued1);
        check("final_m0_pending", exp_rd0.size(), 0);
        check("final_m1_pending", exp_rd1.size(), 0);
        check("never_both_strobes", both_hi, 0);
        check("never_consecutive_strobes", consec, 0);
        check("m0_rdat_held", bus.m0_rdat, last_rd[0]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
